uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: receives bytes, echoes each one back on tx_o, and
// assembles multi-byte command frames into registered configuration outputs.
module uart_cmd_decoder #(
   parameter int SYS_CLK   = 50_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BIT  = 1,
   parameter int DATA_BIT  = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_i,
   output logic                tx_o,
   output logic                rx_done_tick_o,
   output logic [7:0]          rx_data_o,
   output logic                tx_done_tick_o,
   output logic [8:0]          amount_o,
   output logic [DATA_BIT-1:0] output_pattern_o,
   output logic [DATA_BIT-1:0] freq_pattern_o,
   output logic [7:0]          sel_out_o,
   output logic [1:0]          mode_o,
   output logic                enable_o,
   output logic                run_o,
   output logic                idle_o,
   output logic [7:0]          slow_period_o,
   output logic [7:0]          fast_period_o,
   output logic [7:0]          repeat_o,
   output logic [7:0]          cmd_o,
   output logic                done_tick_o
);

   localparam int DIVISOR    = (SYS_CLK + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int DIV_W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int PAT_BYTES  = DATA_BIT / 8;
   localparam int STOP_TICKS = 16 * STOP_BIT;

   localparam logic [7:0] CMD_DATA   = 8'h01;
   localparam logic [7:0] CMD_FREQ   = 8'h02;
   localparam logic [7:0] CMD_PERIOD = 8'h03;
   localparam logic [7:0] CMD_CTRL   = 8'h04;
   localparam logic [7:0] CMD_REPEAT = 8'h05;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {IDLE, CHAN, AMT, PAT, ARG0, ARG1} dec_state_t;

   logic [DIV_W-1:0]    div_count;
   logic                tick;
   logic                rx_meta, rx_sync, rx_prev;
   rx_state_t           rx_state;
   logic [3:0]          rx_ticks, rx_bits;
   logic [7:0]          rx_shift;
   tx_state_t           tx_state;
   logic [7:0]          tx_ticks;
   logic [3:0]          tx_bits;
   logic [7:0]          tx_shift;
   dec_state_t          state;
   logic [7:0]          code, chan, arg0, amount;
   logic [8:0]          count;
   logic [DATA_BIT-1:0] work, placed;

   // Free-running 16x oversampling tick shared by receiver and transmitter
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         div_count <= '0;
         tick      <= 1'b0;
      end else if (div_count == DIV_W'(DIVISOR - 1)) begin
         div_count <= '0;
         tick      <= 1'b1;
      end else begin
         div_count <= div_count + DIV_W'(1);
         tick      <= 1'b0;
      end
   end

   // Two-flop synchronizer plus one history flop for start-edge detection
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver: confirm start at half bit, sample data mid-bit, deliver at mid-stop
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_state       <= RX_IDLE;
         rx_ticks       <= '0;
         rx_bits        <= '0;
         rx_shift       <= '0;
         rx_data_o      <= '0;
         rx_done_tick_o <= 1'b0;
      end else begin
         rx_done_tick_o <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
                  rx_ticks <= '0;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_ticks == 4'd7) begin
                     rx_ticks <= '0;
                     rx_bits  <= '0;
                     rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_ticks <= rx_ticks + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (rx_ticks == 4'd15) begin
                     rx_ticks <= '0;
                     rx_shift <= {rx_sync, rx_shift[7:1]};
                     if (rx_bits == 4'(DATA_BITS - 1)) rx_state <= RX_STOP;
                     else rx_bits <= rx_bits + 4'd1;
                  end else begin
                     rx_ticks <= rx_ticks + 4'd1;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (rx_ticks == 4'd15) begin
                     rx_state       <= RX_IDLE;
                     rx_done_tick_o <= 1'b1;
                     rx_data_o      <= rx_shift;
                  end else begin
                     rx_ticks <= rx_ticks + 4'd1;
                  end
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Transmitter echoing each received byte; new requests while busy are dropped
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tx_state       <= TX_IDLE;
         tx_ticks       <= '0;
         tx_bits        <= '0;
         tx_shift       <= '0;
         tx_o           <= 1'b1;
         tx_done_tick_o <= 1'b0;
      end else begin
         tx_done_tick_o <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               tx_o <= 1'b1;
               if (rx_done_tick_o) begin
                  tx_shift <= rx_data_o;
                  tx_o     <= 1'b0;
                  tx_ticks <= '0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  if (tx_ticks == 8'd15) begin
                     tx_ticks <= '0;
                     tx_bits  <= '0;
                     tx_o     <= tx_shift[0];
                     tx_state <= TX_DATA;
                  end else begin
                     tx_ticks <= tx_ticks + 8'd1;
                  end
               end
            end
            TX_DATA: begin
               if (tick) begin
                  if (tx_ticks == 8'd15) begin
                     tx_ticks <= '0;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     if (tx_bits == 4'(DATA_BITS - 1)) begin
                        tx_o     <= 1'b1;
                        tx_state <= TX_STOP;
                     end else begin
                        tx_o    <= tx_shift[1];
                        tx_bits <= tx_bits + 4'd1;
                     end
                  end else begin
                     tx_ticks <= tx_ticks + 8'd1;
                  end
               end
            end
            TX_STOP: begin
               if (tick) begin
                  if (tx_ticks == 8'(STOP_TICKS - 1)) begin
                     tx_state       <= TX_IDLE;
                     tx_done_tick_o <= 1'b1;
                  end else begin
                     tx_ticks <= tx_ticks + 8'd1;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Working pattern with the current byte dropped into its slot; bytes past the width fall away
   always_comb begin
      placed = work;
      for (int i = 0; i < PAT_BYTES; i++) begin
         if (count == 9'(i)) placed[8*i +: 8] = rx_data_o;
      end
   end

   // Frame decoder: steps once per received byte and commits outputs on the final byte
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state            <= IDLE;
         code             <= '0;
         chan             <= '0;
         arg0             <= '0;
         amount           <= '0;
         count            <= '0;
         work             <= '0;
         amount_o         <= '0;
         output_pattern_o <= '0;
         freq_pattern_o   <= '0;
         sel_out_o        <= '0;
         mode_o           <= '0;
         enable_o         <= 1'b0;
         run_o            <= 1'b0;
         idle_o           <= 1'b0;
         slow_period_o    <= '0;
         fast_period_o    <= '0;
         repeat_o         <= '0;
         cmd_o            <= '0;
         done_tick_o      <= 1'b0;
      end else begin
         done_tick_o <= 1'b0;
         run_o       <= 1'b0;
         if (rx_done_tick_o) begin
            case (state)
               IDLE: begin
                  code <= rx_data_o;
                  case (rx_data_o)
                     CMD_FREQ:                      state <= AMT;
                     CMD_DATA, CMD_REPEAT, CMD_CTRL: state <= CHAN;
                     CMD_PERIOD:                    state <= ARG0;
                     default:                       state <= IDLE;
                  endcase
               end
               CHAN: begin
                  chan  <= rx_data_o;
                  state <= (code == CMD_DATA) ? AMT : ARG1;
               end
               AMT: begin
                  amount <= rx_data_o;
                  count  <= '0;
                  work   <= '0;
                  state  <= PAT;
               end
               PAT: begin
                  work <= placed;
                  if (count == {1'b0, amount}) begin
                     done_tick_o <= 1'b1;
                     cmd_o       <= code;
                     amount_o    <= {1'b0, amount};
                     if (code == CMD_FREQ) begin
                        freq_pattern_o <= placed;
                     end else begin
                        output_pattern_o <= placed;
                        sel_out_o        <= chan;
                     end
                     state <= IDLE;
                  end else begin
                     count <= count + 9'd1;
                  end
               end
               ARG0: begin
                  arg0  <= rx_data_o;
                  state <= ARG1;
               end
               ARG1: begin
                  done_tick_o <= 1'b1;
                  cmd_o       <= code;
                  state       <= IDLE;
                  case (code)
                     CMD_PERIOD: begin
                        slow_period_o <= arg0;
                        fast_period_o <= rx_data_o;
                     end
                     CMD_REPEAT: begin
                        sel_out_o <= chan;
                        repeat_o  <= rx_data_o;
                     end
                     CMD_CTRL: begin
                        sel_out_o <= chan;
                        idle_o    <= rx_data_o[3];
                        mode_o    <= rx_data_o[2:1];
                        enable_o  <= rx_data_o[0];
                        run_o     <= rx_data_o[0];
                     end
                     default: ;
                  endcase
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: serial frames in, echo and decoded outputs checked
// against a frame-level model of the command set.
module tb_uart_cmd_decoder;

   localparam int SYS_CLK  = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int DATA_BIT = 32;
   localparam int NB       = DATA_BIT / 8;
   localparam int BIT      = 32;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                rx_i = 1'b1;
   logic                tx_o, rx_done_tick_o, tx_done_tick_o;
   logic [7:0]          rx_data_o;
   logic [8:0]          amount_o;
   logic [DATA_BIT-1:0] output_pattern_o, freq_pattern_o;
   logic [7:0]          sel_out_o, slow_period_o, fast_period_o, repeat_o, cmd_o;
   logic [1:0]          mode_o;
   logic                enable_o, run_o, idle_o, done_tick_o;

   uart_cmd_decoder #(
      .SYS_CLK(SYS_CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BIT(1), .DATA_BIT(DATA_BIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .tx_o(tx_o),
      .rx_done_tick_o(rx_done_tick_o), .rx_data_o(rx_data_o),
      .tx_done_tick_o(tx_done_tick_o), .amount_o(amount_o),
      .output_pattern_o(output_pattern_o), .freq_pattern_o(freq_pattern_o),
      .sel_out_o(sel_out_o), .mode_o(mode_o), .enable_o(enable_o), .run_o(run_o),
      .idle_o(idle_o), .slow_period_o(slow_period_o), .fast_period_o(fast_period_o),
      .repeat_o(repeat_o), .cmd_o(cmd_o), .done_tick_o(done_tick_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]          cmd, sel, slow, fast, rep;
      logic [8:0]          amt;
      logic [DATA_BIT-1:0] pat;
      logic [1:0]          mode;
      logic                en, idle;
   } rec_t;

   rec_t       rec_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] echo_q[$];
   logic [7:0] frame_q[$];

   logic [7:0]          m_cmd, m_sel, m_slow, m_fast, m_rep;
   logic [8:0]          m_amt;
   logic [DATA_BIT-1:0] m_opat, m_fpat;
   logic [1:0]          m_mode;
   logic                m_en, m_idle;

   int tests_run = 0, tests_failed = 0;
   int done_count = 0, run_count = 0, echo_count = 0, bytes_sent = 0;
   int d0, r0;
   logic prev_rx_done = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearModel();
      m_cmd = '0; m_sel = '0; m_slow = '0; m_fast = '0; m_rep = '0; m_amt = '0;
      m_opat = '0; m_fpat = '0; m_mode = '0; m_en = 1'b0; m_idle = 1'b0;
   endtask

   // Turn the frame in frame_q into the set of output values it must produce
   task automatic queueFrame();
      rec_t r;
      logic [7:0] flags;
      int base;
      r = '{cmd: frame_q[0], sel: 8'h0, slow: 8'h0, fast: 8'h0, rep: 8'h0,
            amt: 9'h0, pat: '0, mode: 2'b0, en: 1'b0, idle: 1'b0};
      base = 0;
      case (frame_q[0])
         8'h03: begin r.slow = frame_q[1]; r.fast = frame_q[2]; end
         8'h02, 8'h01: begin
            if (frame_q[0] == 8'h01) begin r.sel = frame_q[1]; base = 1; end
            r.amt = {1'b0, frame_q[1 + base]};
            for (int i = 0; i <= int'(frame_q[1 + base]); i++)
               if (i < NB) r.pat[8*i +: 8] = frame_q[2 + base + i];
         end
         8'h05: begin r.sel = frame_q[1]; r.rep = frame_q[2]; end
         8'h04: begin
            flags = frame_q[2];
            r.sel = frame_q[1]; r.en = flags[0]; r.mode = flags[2:1]; r.idle = flags[3];
         end
         default: return;
      endcase
      rec_q.push_back(r);
   endtask

   // Drive one UART byte on rx_i, optionally with a low stop bit, then idle two bits
   task automatic applyStimulus(input logic [7:0] b, input bit stop_low);
      rx_q.push_back(b);
      echo_q.push_back(b);
      bytes_sent++;
      @(negedge clk);
      rx_i = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx_i = ~stop_low;
      repeat (BIT) @(negedge clk);
      rx_i = 1'b1;
      repeat (2 * BIT) @(negedge clk);
   endtask

   task automatic sendFrame();
      queueFrame();
      foreach (frame_q[i]) applyStimulus(frame_q[i], 1'b0);
   endtask

   // Compare process: every reset cycle and every cycle around a received byte
   always @(negedge clk) begin
      rec_t r;
      logic exp_run;
      exp_run = 1'b0;
      if (!rst_n && done_tick_o) begin
         done_count++;
         checkOutput("done_after_rx", 64'(prev_rx_done), 64'd1);
         if (rec_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL unexpected_done: got done_tick_o=1, expected no completion");
         end else begin
            r = rec_q.pop_front();
            m_cmd = r.cmd;
            case (r.cmd)
               8'h03: begin m_slow = r.slow; m_fast = r.fast; end
               8'h02: begin m_amt = r.amt; m_fpat = r.pat; end
               8'h01: begin m_sel = r.sel; m_amt = r.amt; m_opat = r.pat; end
               8'h05: begin m_sel = r.sel; m_rep = r.rep; end
               8'h04: begin m_sel = r.sel; m_en = r.en; m_mode = r.mode; m_idle = r.idle; end
               default: ;
            endcase
            exp_run = (r.cmd == 8'h04) && r.en;
         end
      end
      if (run_o) run_count++;
      if (!rst_n && rx_done_tick_o) begin
         if (rx_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL unexpected_rx: got rx_data_o=0x%0h, expected no byte", rx_data_o);
         end else begin
            checkOutput("rx_data", 64'(rx_data_o), 64'(rx_q.pop_front()));
         end
      end
      if (rst_n) begin
         checkOutput("rst_tx", 64'(tx_o), 64'd1);
         checkOutput("rst_done", 64'(done_tick_o), 64'd0);
         checkOutput("rst_rx_done", 64'(rx_done_tick_o), 64'd0);
         checkOutput("rst_rx_data", 64'(rx_data_o), 64'd0);
      end
      if (rst_n || done_tick_o || rx_done_tick_o || prev_rx_done) begin
         checkOutput("cmd", 64'(cmd_o), 64'(m_cmd));
         checkOutput("slow", 64'(slow_period_o), 64'(m_slow));
         checkOutput("fast", 64'(fast_period_o), 64'(m_fast));
         checkOutput("amount", 64'(amount_o), 64'(m_amt));
         checkOutput("freq_pat", 64'(freq_pattern_o), 64'(m_fpat));
         checkOutput("out_pat", 64'(output_pattern_o), 64'(m_opat));
         checkOutput("sel", 64'(sel_out_o), 64'(m_sel));
         checkOutput("repeat", 64'(repeat_o), 64'(m_rep));
         checkOutput("mode", 64'(mode_o), 64'(m_mode));
         checkOutput("enable", 64'(enable_o), 64'(m_en));
         checkOutput("idle", 64'(idle_o), 64'(m_idle));
         checkOutput("run", 64'(run_o), 64'(exp_run));
      end
      prev_rx_done = rx_done_tick_o;
   end

   // Echo monitor: decodes tx_o at mid-bit and matches it against the bytes sent
   initial begin
      logic [7:0] got;
      bit seen;
      forever begin
         @(negedge tx_o);
         repeat (BIT / 2) @(negedge clk);
         checkOutput("echo_start", 64'(tx_o), 64'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            got[i] = tx_o;
         end
         repeat (BIT) @(negedge clk);
         checkOutput("echo_stop", 64'(tx_o), 64'd1);
         seen = 1'b0;
         for (int k = 0; k < 2 * BIT && !seen; k++) begin
            @(negedge clk);
            if (tx_done_tick_o) seen = 1'b1;
         end
         checkOutput("echo_done_tick", 64'(seen), 64'd1);
         if (echo_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL unexpected_echo: got 0x%0h, expected no echo", got);
         end else begin
            checkOutput("echo_byte", 64'(got), 64'(echo_q.pop_front()));
         end
         echo_count++;
      end
   end

   // Main sequence of directed frames with hand-computed expectations
   initial begin
      clearModel();
      repeat (5) @(negedge clk);
      checkOutput("reset_tx", 64'(tx_o), 64'd1);
      checkOutput("reset_cmd", 64'(cmd_o), 64'd0);
      checkOutput("reset_freq", 64'(freq_pattern_o), 64'd0);
      @(posedge clk); #2 rst_n = 1'b0;
      repeat (10) @(negedge clk);

      d0 = done_count;
      frame_q = '{8'h03, 8'h14, 8'h05};
      sendFrame();
      checkOutput("period_slow", 64'(slow_period_o), 64'h14);
      checkOutput("period_fast", 64'(fast_period_o), 64'h05);
      checkOutput("period_cmd", 64'(cmd_o), 64'h03);
      checkOutput("period_done_count", 64'(done_count - d0), 64'd1);

      frame_q = '{8'h02, 8'h03, 8'h44, 8'h33, 8'h22, 8'h11};
      sendFrame();
      checkOutput("freq_pat_lit", 64'(freq_pattern_o), 64'h11223344);
      checkOutput("freq_amt_lit", 64'(amount_o), 64'd3);

      frame_q = '{8'h01, 8'h05, 8'h03, 8'hEE, 8'hDD, 8'hCC, 8'hBB};
      sendFrame();
      checkOutput("data_pat_lit", 64'(output_pattern_o), 64'hBBCCDDEE);
      checkOutput("data_sel_lit", 64'(sel_out_o), 64'd5);
      checkOutput("data_amt_lit", 64'(amount_o), 64'd3);

      r0 = run_count;
      frame_q = '{8'h05, 8'h05, 8'h03};
      sendFrame();
      frame_q = '{8'h04, 8'h05, 8'h0B};
      sendFrame();
      checkOutput("repeat_lit", 64'(repeat_o), 64'd3);
      checkOutput("ctrl_idle_lit", 64'(idle_o), 64'd1);
      checkOutput("ctrl_mode_lit", 64'(mode_o), 64'b01);
      checkOutput("ctrl_en_lit", 64'(enable_o), 64'd1);
      checkOutput("ctrl_run_count", 64'(run_count - r0), 64'd1);

      d0 = done_count;
      applyStimulus(8'h7F, 1'b0);
      checkOutput("unknown_no_done", 64'(done_count - d0), 64'd0);
      checkOutput("unknown_cmd_kept", 64'(cmd_o), 64'h04);

      frame_q = '{8'h02, 8'h00, 8'h5A};
      sendFrame();
      checkOutput("freq_single_pat", 64'(freq_pattern_o), 64'h0000005A);
      checkOutput("freq_single_amt", 64'(amount_o), 64'd0);

      frame_q = '{8'h02, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      sendFrame();
      checkOutput("freq_over_pat", 64'(freq_pattern_o), 64'h04030201);
      checkOutput("freq_over_amt", 64'(amount_o), 64'd5);
      checkOutput("freq_keeps_out_pat", 64'(output_pattern_o), 64'hBBCCDDEE);

      r0 = run_count;
      frame_q = '{8'h04, 8'h02, 8'h04};
      sendFrame();
      checkOutput("ctrl2_sel", 64'(sel_out_o), 64'd2);
      checkOutput("ctrl2_mode", 64'(mode_o), 64'b10);
      checkOutput("ctrl2_en", 64'(enable_o), 64'd0);
      checkOutput("ctrl2_no_run", 64'(run_count - r0), 64'd0);

      frame_q = '{8'h03, 8'h21, 8'h42};
      queueFrame();
      applyStimulus(8'h03, 1'b0);
      applyStimulus(8'h21, 1'b0);
      applyStimulus(8'h42, 1'b1);
      checkOutput("lowstop_slow", 64'(slow_period_o), 64'h21);
      checkOutput("lowstop_fast", 64'(fast_period_o), 64'h42);

      d0 = done_count;
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h03, 1'b0);
      repeat (12 * BIT) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      clearModel();
      repeat (4) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("abort_no_done", 64'(done_count - d0), 64'd0);
      checkOutput("abort_freq", 64'(freq_pattern_o), 64'd0);
      checkOutput("abort_amt", 64'(amount_o), 64'd0);
      checkOutput("abort_cmd", 64'(cmd_o), 64'd0);
      checkOutput("abort_sel", 64'(sel_out_o), 64'd0);

      frame_q = '{8'h03, 8'h01, 8'h02};
      sendFrame();
      checkOutput("post_reset_slow", 64'(slow_period_o), 64'h01);
      checkOutput("post_reset_fast", 64'(fast_period_o), 64'h02);
      checkOutput("post_reset_freq", 64'(freq_pattern_o), 64'd0);

      repeat (12 * BIT) @(negedge clk);
      checkOutput("pending_frames", 64'(rec_q.size()), 64'd0);
      checkOutput("pending_rx", 64'(rx_q.size()), 64'd0);
      checkOutput("echo_count", 64'(echo_count), 64'(bytes_sent));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
